// File: rtl/seat_pkg.sv
// Shared types and sizes for the seat controller: seat/op/response encodings,
// FSM states, the latched request record and the away-timeout test.
package seat_pkg;

  localparam int NUM_SEATS = 32;
  localparam int SEAT_W    = 5;
  localparam int TIME_W    = 11;
  localparam int STU_W     = 32;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    AWAY   = 2'd1,
    SEATED = 2'd2
  } seat_state_t;

  typedef enum logic [1:0] {
    OP_LEAVE = 2'd0,
    OP_AWAY  = 2'd1,
    OP_SEAT  = 2'd2,
    OP_BAD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    RESP_OK        = 2'd0,
    RESP_BUSY      = 2'd1,
    RESP_NOT_OWNER = 2'd2,
    RESP_BAD_OP    = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_CLEAR = 2'd3
  } fsm_t;

  typedef struct packed {
    op_t               op;
    logic [SEAT_W-1:0] seat;
    logic [STU_W-1:0]  student;
  } req_t;

  typedef struct packed {
    seat_state_t       st;
    logic [STU_W-1:0]  stu;
    logic [TIME_W-1:0] stamp;
  } entry_t;

  // Elapsed time is taken modulo 2^TIME_W so a stamp just before the wrap still ages correctly.
  function automatic logic is_expired(input seat_state_t       st,
                                      input logic [TIME_W-1:0] stamp,
                                      input logic [TIME_W-1:0] now_t,
                                      input logic [TIME_W-1:0] limit);
    logic [TIME_W-1:0] elapsed;
    elapsed = now_t - stamp;
    return (st == AWAY) && (elapsed > limit);
  endfunction

endpackage

// File: rtl/seat_ctrl_if.sv
// Request/response handshake between a client and seat_ctrl.
// The client drives the master side; seat_ctrl uses the slave side.
interface seat_ctrl_if;
  import seat_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [SEAT_W-1:0]    req_seat;
  logic [STU_W-1:0]     req_student;
  logic                 resp_valid;
  logic [1:0]           resp_code;

  modport master (
    output req_valid, req_op, req_seat, req_student,
    input  req_ready, resp_valid, resp_code
  );

  modport slave (
    input  req_valid, req_op, req_seat, req_student,
    output req_ready, resp_valid, resp_code
  );

endinterface

// File: rtl/seat_time_base.sv
// Minute time base plus the pending-sweep flag; a tick in the same cycle as
// sweep_start wins so the tick is never lost.
module seat_time_base
  import seat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_min,
  input  logic              sweep_start,
  output logic [TIME_W-1:0] now_time,
  output logic              sweep_pend
);

  logic [TIME_W-1:0] now_q, now_d;
  logic              pend_q, pend_d;

  always_comb begin
    now_d  = now_q;
    pend_d = pend_q;
    if (tick_min) begin
      now_d  = now_q + TIME_W'(1);
      pend_d = 1'b1;
    end else if (sweep_start) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      now_q  <= now_d;
      pend_q <= pend_d;
    end
  end

  assign now_time   = now_q;
  assign sweep_pend = pend_q;

endmodule

// File: rtl/seat_ctrl.sv
// Seat request sequencer with shadow seat table, away-timeout sweep and bulk clear.
// Optional occupancy counter output occ_count is built when SEAT_CTRL_OCC_EN is defined.
module seat_ctrl
  import seat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_min,
  input  logic [TIME_W-1:0] limit_time,
  input  logic              clear_all,
  seat_ctrl_if.slave        bus,
  output logic [TIME_W-1:0] now_time,
  output logic              rst_mem,
  output logic              write_mem,
  output logic [SEAT_W-1:0] Seat_No_mem,
  output logic [STU_W-1:0]  Student_No_mem,
  output logic [TIME_W-1:0] Time_mem,
  output logic [1:0]        Seat_State_mem
`ifdef SEAT_CTRL_OCC_EN
  ,
  output logic [5:0]        occ_count
`endif
);

  fsm_t              state_q, state_d;
  logic [SEAT_W-1:0] idx_q, idx_d;
  req_t              req_q, req_d;
  logic              sweep_start;
  logic              sweep_pend;
  logic [TIME_W-1:0] now_q;

  logic              clr;
  logic              wr_en;
  logic [SEAT_W-1:0] wr_seat;
  seat_state_t       wr_state;
  logic [STU_W-1:0]  wr_stu;
  logic [TIME_W-1:0] wr_time;
  logic              resp_v;
  resp_t             resp_c;

  entry_t            tbl [NUM_SEATS];

  seat_time_base u_time_base (
    .clk         (clk),
    .rst         (rst),
    .tick_min    (tick_min),
    .sweep_start (sweep_start),
    .now_time    (now_q),
    .sweep_pend  (sweep_pend)
  );

  // Shadow table: one register per seat, written by the same strobe that hits the memory.
  for (genvar gi = 0; gi < NUM_SEATS; gi++) begin : g_seat
    entry_t entry_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_q <= '{st: EMPTY, stu: '0, stamp: '0};
      end else if (clr) begin
        entry_q <= '{st: EMPTY, stu: '0, stamp: '0};
      end else if (wr_en && (wr_seat == SEAT_W'(gi))) begin
        entry_q <= '{st: wr_state, stu: wr_stu, stamp: wr_time};
      end
    end

    assign tbl[gi] = entry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      req_q   <= '{op: OP_LEAVE, seat: '0, student: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_d       = req_q;
    sweep_start = 1'b0;
    clr         = 1'b0;
    wr_en       = 1'b0;
    wr_seat     = '0;
    wr_state    = EMPTY;
    wr_stu      = '0;
    wr_time     = '0;
    resp_v      = 1'b0;
    resp_c      = RESP_OK;

    case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          state_d = ST_CLEAR;
        end else if (sweep_pend) begin
          state_d     = ST_SWEEP;
          idx_d       = '0;
          sweep_start = 1'b1;
        end else if (bus.req_valid) begin
          state_d = ST_EXEC;
          req_d   = '{op: op_t'(bus.req_op), seat: bus.req_seat, student: bus.req_student};
        end
      end

      ST_EXEC: begin
        // A clear landing on the execute cycle swallows the request entirely.
        if (clear_all) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
          resp_v  = 1'b1;
          case (req_q.op)
            OP_SEAT: begin
              if (tbl[req_q.seat].st == EMPTY || tbl[req_q.seat].stu == req_q.student) begin
                wr_en    = 1'b1;
                wr_state = SEATED;
                wr_stu   = req_q.student;
                wr_time  = now_q;
              end else begin
                resp_c = RESP_BUSY;
              end
            end
            OP_AWAY: begin
              if (tbl[req_q.seat].st == SEATED && tbl[req_q.seat].stu == req_q.student) begin
                wr_en    = 1'b1;
                wr_state = AWAY;
                wr_stu   = req_q.student;
                wr_time  = now_q;
              end else begin
                resp_c = RESP_NOT_OWNER;
              end
            end
            OP_LEAVE: begin
              if (tbl[req_q.seat].st != EMPTY && tbl[req_q.seat].stu == req_q.student) begin
                wr_en = 1'b1;
              end else begin
                resp_c = RESP_NOT_OWNER;
              end
            end
            default: resp_c = RESP_BAD_OP;
          endcase
          if (wr_en) begin
            wr_seat = req_q.seat;
          end
        end
      end

      ST_SWEEP: begin
        if (clear_all) begin
          state_d = ST_CLEAR;
        end else begin
          if (is_expired(tbl[idx_q].st, tbl[idx_q].stamp, now_q, limit_time)) begin
            wr_en   = 1'b1;
            wr_seat = idx_q;
          end
          idx_d = idx_q + SEAT_W'(1);
          if (idx_q == SEAT_W'(NUM_SEATS - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CLEAR: begin
        clr     = 1'b1;
        state_d = clear_all ? ST_CLEAR : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEAT_CTRL_OCC_EN
  logic [5:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (wr_en) begin
      if (wr_state != EMPTY && tbl[wr_seat].st == EMPTY) begin
        occ_d = occ_q + 6'd1;
      end else if (wr_state == EMPTY && tbl[wr_seat].st != EMPTY) begin
        occ_d = occ_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_count = occ_q;
`endif

  assign bus.req_ready  = (state_q == ST_IDLE) && !clear_all && !sweep_pend && !rst;
  assign bus.resp_valid = resp_v;
  assign bus.resp_code  = resp_c;

  assign now_time       = now_q;
  assign rst_mem        = clr;
  assign write_mem      = wr_en;
  assign Seat_No_mem    = wr_seat;
  assign Student_No_mem = wr_stu;
  assign Time_mem       = wr_time;
  assign Seat_State_mem = wr_state;

endmodule

// File: tb/tb_seat_ctrl.sv
// Directed bench for seat_ctrl: expected writes/responses are queued when a
// request or tick is driven and popped by a monitor on the falling edge.
module tb_seat_ctrl;
  import seat_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick_min = 1'b0;
  logic              clear_all = 1'b0;
  logic [TIME_W-1:0] limit_time = 11'd3;
  logic [TIME_W-1:0] now_time;
  logic              rst_mem;
  logic              write_mem;
  logic [SEAT_W-1:0] Seat_No_mem;
  logic [STU_W-1:0]  Student_No_mem;
  logic [TIME_W-1:0] Time_mem;
  logic [1:0]        Seat_State_mem;
`ifdef SEAT_CTRL_OCC_EN
  logic [5:0]        occ_count;
`endif

  seat_ctrl_if bus ();

  seat_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .tick_min       (tick_min),
    .limit_time     (limit_time),
    .clear_all      (clear_all),
    .bus            (bus),
    .now_time       (now_time),
    .rst_mem        (rst_mem),
    .write_mem      (write_mem),
    .Seat_No_mem    (Seat_No_mem),
    .Student_No_mem (Student_No_mem),
    .Time_mem       (Time_mem),
    .Seat_State_mem (Seat_State_mem)
`ifdef SEAT_CTRL_OCC_EN
    ,
    .occ_count      (occ_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEAT_W-1:0] seat;
    logic [1:0]        st;
    logic [STU_W-1:0]  stu;
    logic [TIME_W-1:0] tm;
  } wr_t;

  wr_t               wr_q[$];
  logic [1:0]        resp_q[$];
  wr_t               exp_w;
  logic [1:0]        exp_r;
  int                n_checks = 0;
  int                n_pass = 0;
  int                n_fail = 0;
  logic [TIME_W-1:0] tb_now = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and response must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_mem || rst_mem) begin
        check("wr_rst_exclusive", 64'(write_mem & rst_mem), 64'd0);
      end
      if (write_mem) begin
        $display("write seat=%0d state=%0d stu=%0d time=%0d",
                 Seat_No_mem, Seat_State_mem, Student_No_mem, Time_mem);
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 64'(write_mem), 64'd0);
        end else begin
          exp_w = wr_q.pop_front();
          check("wr_fields", 64'({Seat_No_mem, Seat_State_mem, Student_No_mem, Time_mem}), 64'(exp_w));
        end
      end
      if (bus.resp_valid) begin
        $display("resp code=%0d", bus.resp_code);
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          exp_r = resp_q.pop_front();
          check("resp_code", 64'(bus.resp_code), 64'(exp_r));
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [SEAT_W-1:0] seat,
                        input logic [STU_W-1:0] stu, input logic [1:0] code,
                        input bit wr, input logic [1:0] wst,
                        input logic [STU_W-1:0] wstu, input logic [TIME_W-1:0] wtm);
    int n = 0;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_seat    = seat;
    bus.req_student = stu;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    check("req_ready_wait", 64'(bus.req_ready), 64'd1);
    resp_q.push_back(code);
    if (wr) wr_q.push_back({seat, wst, wstu, wtm});
    step();
    bus.req_valid = 1'b0;
    check("exec_resp_valid", 64'(bus.resp_valid), 64'd1);
    step();
  endtask

  task automatic tick_sweep();
    int n = 0;
    tick_min = 1'b1;
    step();
    tick_min = 1'b0;
    tb_now++;
    while (!bus.req_ready && n < 80) begin
      step();
      n++;
    end
    check("sweep_done", 64'(bus.req_ready), 64'd1);
    check("now_time", 64'(now_time), 64'(tb_now));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.req_valid   = 1'b0;
    bus.req_op      = '0;
    bus.req_seat    = '0;
    bus.req_student = '0;

    step();
    check("rst_now_time", 64'(now_time), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_write_mem", 64'(write_mem), 64'd0);
    check("rst_rst_mem", 64'(rst_mem), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    step();
    check("idle_ready", 64'(bus.req_ready), 64'd1);

    // Basic request rules on seat 5.
    do_req(OP_SEAT, 5'd5, 32'd100, RESP_OK, 1, SEATED, 32'd100, tb_now);
    check("ready_at_n2", 64'(bus.req_ready), 64'd1);
`ifdef SEAT_CTRL_OCC_EN
    check("occ_one", 64'(occ_count), 64'd1);
`endif
    do_req(OP_SEAT, 5'd5, 32'd200, RESP_BUSY, 0, EMPTY, 32'd0, 11'd0);
    do_req(OP_AWAY, 5'd5, 32'd200, RESP_NOT_OWNER, 0, EMPTY, 32'd0, 11'd0);
    do_req(OP_LEAVE, 5'd5, 32'd100, RESP_OK, 1, EMPTY, 32'd0, 11'd0);
    do_req(2'd3, 5'd2, 32'd1, RESP_BAD_OP, 0, EMPTY, 32'd0, 11'd0);
    do_req(OP_LEAVE, 5'd9, 32'd0, RESP_NOT_OWNER, 0, EMPTY, 32'd0, 11'd0);
    do_req(OP_AWAY, 5'd9, 32'd0, RESP_NOT_OWNER, 0, EMPTY, 32'd0, 11'd0);

    // Timeout with limit 3: away at 10, released by the sweep at 14.
    repeat (10) tick_sweep();
    do_req(OP_SEAT, 5'd7, 32'd77, RESP_OK, 1, SEATED, 32'd77, tb_now);
    do_req(OP_AWAY, 5'd7, 32'd77, RESP_OK, 1, AWAY, 32'd77, tb_now);
    repeat (3) tick_sweep();
    wr_q.push_back({5'd7, 2'(EMPTY), 32'd0, 11'd0});
    tick_sweep();
    do_req(OP_SEAT, 5'd7, 32'd5, RESP_OK, 1, SEATED, 32'd5, tb_now);
    do_req(OP_AWAY, 5'd7, 32'd5, RESP_OK, 1, AWAY, 32'd5, tb_now);
    do_req(OP_SEAT, 5'd7, 32'd5, RESP_OK, 1, SEATED, 32'd5, tb_now);

    // Run the clock base up to 2046 with back-to-back ticks.
    tick_min = 1'b1;
    repeat (2032) step();
    tick_min = 1'b0;
    tb_now = tb_now + 11'd2032;
    cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("bulk_sweep_done", 64'(bus.req_ready), 64'd1);
    check("now_2046", 64'(now_time), 64'(tb_now));

    // Wrap: away at 2046, limit 2 -> kept at 0, released at 1.
    limit_time = 11'd2;
    do_req(OP_SEAT, 5'd3, 32'd33, RESP_OK, 1, SEATED, 32'd33, tb_now);
    do_req(OP_AWAY, 5'd3, 32'd33, RESP_OK, 1, AWAY, 32'd33, tb_now);
    tick_sweep();
    tick_sweep();
    wr_q.push_back({5'd3, 2'(EMPTY), 32'd0, 11'd0});
    tick_sweep();

    // Request held during a sweep waits 33 cycles (pending IDLE + 32 sweep).
    tick_min = 1'b1;
    step();
    tick_min = 1'b0;
    tb_now++;
    bus.req_valid   = 1'b1;
    bus.req_op      = OP_SEAT;
    bus.req_seat    = 5'd20;
    bus.req_student = 32'd9;
    cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      cnt++;
      step();
    end
    check("ready_low_cycles", 64'(cnt), 64'd33);
    do_req(OP_SEAT, 5'd20, 32'd9, RESP_OK, 1, SEATED, 32'd9, tb_now);
    do_req(OP_AWAY, 5'd20, 32'd9, RESP_OK, 1, AWAY, 32'd9, tb_now);
    tick_sweep();
    tick_sweep();

    // Clear at sweep index 12 aborts the sweep that would release seat 20.
    tick_min = 1'b1;
    step();
    tick_min = 1'b0;
    tb_now++;
    repeat (13) step();
    clear_all = 1'b1;
    step();
    check("clr_sweep_rst_mem", 64'(rst_mem), 64'd1);
    check("clr_sweep_no_write", 64'(write_mem), 64'd0);
    clear_all = 1'b0;
    step();
    check("clr_sweep_rst_mem_off", 64'(rst_mem), 64'd0);
    check("clr_sweep_now", 64'(now_time), 64'(tb_now));
`ifdef SEAT_CTRL_OCC_EN
    check("occ_after_clear", 64'(occ_count), 64'd0);
`endif
    tick_sweep();
    do_req(OP_SEAT, 5'd7, 32'd1234, RESP_OK, 1, SEATED, 32'd1234, tb_now);
    do_req(OP_LEAVE, 5'd20, 32'd9, RESP_NOT_OWNER, 0, EMPTY, 32'd0, 11'd0);

    // Simultaneous tick and clear: clear first, then a sweep.
    tick_min  = 1'b1;
    clear_all = 1'b1;
    step();
    tick_min  = 1'b0;
    clear_all = 1'b0;
    tb_now++;
    check("tc_rst_mem", 64'(rst_mem), 64'd1);
    check("tc_now", 64'(now_time), 64'(tb_now));
    cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      cnt++;
      step();
    end
    check("tc_ready_low_cycles", 64'(cnt), 64'd34);
    do_req(OP_SEAT, 5'd7, 32'd999, RESP_OK, 1, SEATED, 32'd999, tb_now);

    // Clear on the execute cycle: no response, no write.
    bus.req_valid   = 1'b1;
    bus.req_op      = OP_SEAT;
    bus.req_seat    = 5'd11;
    bus.req_student = 32'd50;
    step();
    bus.req_valid = 1'b0;
    clear_all = 1'b1;
    #1;
    check("exec_clr_no_write", 64'(write_mem), 64'd0);
    check("exec_clr_no_resp", 64'(bus.resp_valid), 64'd0);
    step();
    check("exec_clr_rst_mem", 64'(rst_mem), 64'd1);
    clear_all = 1'b0;
    step();
    do_req(OP_SEAT, 5'd11, 32'd51, RESP_OK, 1, SEATED, 32'd51, tb_now);

    // Asynchronous reset on the execute cycle drops the request.
    bus.req_valid   = 1'b1;
    bus.req_op      = OP_SEAT;
    bus.req_seat    = 5'd15;
    bus.req_student = 32'd7;
    step();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_no_write", 64'(write_mem), 64'd0);
    check("arst_no_resp", 64'(bus.resp_valid), 64'd0);
    check("arst_now", 64'(now_time), 64'd0);
    step();
    step();
    rst = 1'b0;
    tb_now = '0;
    step();
    check("arst_ready", 64'(bus.req_ready), 64'd1);
`ifdef SEAT_CTRL_OCC_EN
    check("occ_after_reset", 64'(occ_count), 64'd0);
`endif
    do_req(OP_SEAT, 5'd11, 32'd52, RESP_OK, 1, SEATED, 32'd52, tb_now);

    step();
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seat_ctrl.md
Name: seat_ctrl

Overview:
Sequencing controller in front of the 32-seat occupancy memory. Accepts seat requests (sit, step away, leave) over a valid/ready handshake and validates them against a shadow seat table. Runs a periodic timeout sweep that releases stale "away" seats. Drives the memory write port and the bulk clear.

Parameters:
NUM_SEATS, 32, seats managed; seat index width is 5 bits.
TIME_W, 11, width of the minute time base and timestamps.
STU_W, 32, student number width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick_min  in  1  one-cycle pulse; advances the time base by 1
limit_time  in  TIME_W  away timeout in minutes
clear_all  in  1  one-cycle pulse; empties all seats
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_op  in  2  0 LEAVE, 1 AWAY, 2 SEAT; 3 is illegal
req_seat  in  5  target seat
req_student  in  STU_W  requesting student
resp_valid  out  1  one-cycle response strobe
resp_code  out  2  0 OK, 1 BUSY, 2 NOT_OWNER, 3 BAD_OP
now_time  out  TIME_W  current time base
rst_mem  out  1  bulk clear strobe to the seat memory
write_mem  out  1  single-seat write strobe
Seat_No_mem  out  5  write address
Student_No_mem  out  STU_W  write data: student
Time_mem  out  TIME_W  write data: timestamp
Seat_State_mem  out  2  write data: 0 EMPTY, 1 AWAY, 2 SEATED

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shadow tables (state, student, stamp) all 0, now_time 0, sweep_pend 0.
- Time base: on tick_min, now_time increments by 1 and wraps from 2047 to 0. sweep_pend is set to 1.
- Timeout arithmetic: elapsed = (now_time - stamp) mod 2^TIME_W. A seat has expired when it is AWAY and elapsed > limit_time (strictly greater).
- FSM states: IDLE, EXEC, SWEEP, CLEAR.
- Priority in IDLE: clear_all, then sweep_pend, then request.
- req_ready: high only in IDLE, and only when clear_all = 0 and sweep_pend = 0.
- Request accept: a request is accepted on req_valid & req_ready. On the next cycle (EXEC), the controller evaluates the request against the shadow table, drives write_mem if the request is granted, and pulses resp_valid with resp_code. It returns to IDLE on the following cycle.
- Request rules:
  - SEAT on EMPTY: write SEATED with stamp now_time; response OK.
  - SEAT on SEATED or AWAY with the same student: write SEATED with a new stamp; response OK.
  - SEAT on SEATED or AWAY with a different student: no write; response BUSY.
  - AWAY by the owner of a SEATED seat: write AWAY with stamp now_time; response OK.
  - AWAY on a seat that is not SEATED, or by a non-owner: no write; response NOT_OWNER.
  - LEAVE by the owner of a SEATED or AWAY seat: write EMPTY, student 0, time 0; response OK.
  - LEAVE on an EMPTY seat, or by a non-owner: no write; response NOT_OWNER.
  - op 3: no write; response BAD_OP.
- SWEEP: clears sweep_pend on entry. Visits index 0..31, one seat per cycle. An expired seat gets a write of EMPTY, student 0, time 0 in that cycle, and the shadow entry is updated. After index 31 the FSM returns to IDLE (32 cycles total). A tick_min during the sweep increments now_time and re-sets sweep_pend, so another sweep follows.
- CLEAR: entered from any state on clear_all, aborting an in-progress sweep or EXEC. An aborted EXEC gets no response and no write. CLEAR asserts rst_mem for exactly one cycle, zeroes the shadow tables, and leaves now_time unchanged. Next state is IDLE.
- Simultaneous tick_min and clear_all: both take effect. Time advances, the clear happens, and the sweep follows the clear.
- write_mem and rst_mem are never high together. At most one write per cycle.
- Asynchronous reset mid-sweep or mid-EXEC: immediate return to reset values; the in-flight request is dropped.

Optional Feature:
SEAT_CTRL_OCC_EN.
- Defined: adds output occ_count[5:0], the number of non-EMPTY seats (0..32). It updates in the cycle after each write or clear and is 0 on reset and after CLEAR.
- Undefined: the port and its counter are absent.

Decomposition:
- Package seat_pkg: seat_state_t enum (EMPTY = 0, AWAY = 1, SEATED = 2), op_t enum, resp_t enum, NUM_SEATS, TIME_W, STU_W.
- One sub-module, seat_time_base: minute counter plus sweep_pend flag, with inputs clk, rst, tick_min and a sweep-start clear.

Test Plan:
- Seat 5 EMPTY, SEAT by student 100 -> req accepted at cycle N; at N+1 write_mem = 1, Seat_No_mem = 5, Seat_State_mem = 2, Time_mem = now_time, resp OK; req_ready high again at N+2.
- Seat 5 SEATED by 100, SEAT by student 200 -> no write, resp BUSY; then AWAY by 200 -> NOT_OWNER; then LEAVE by 100 -> write state 0, resp OK.
- limit_time = 3, seat 7 set AWAY at now_time = 10 -> sweeps at now_time 11..13 perform no write; the sweep at now_time = 14 writes seat 7 EMPTY at sweep cycle index 7.
- Wrap case: seat AWAY at now_time = 2046, limit = 2 -> not expired at time 0 (elapsed 2); expired at time 1 (elapsed 3).
- clear_all pulsed during sweep index 12 -> rst_mem high for one cycle, no further sweep writes, all shadow state EMPTY, now_time unchanged.
- req_valid held during a sweep -> req_ready stays 0 for 32 cycles; the request is accepted on the first IDLE cycle after the sweep.
